dffram_2p: RTL and testbench
============================

# dffram_2p

Parametrised two-port DFF/latch-free register-file RAM: one synchronous read port (port 0) and one byte-masked write port (port 1), configurable word width and depth. It is the successor to the fixed 256x32 single-port macro, for use as a simultaneous read/write scratchpad or FIFO store beside the SoC bus. Adds a read-during-write bypass and an optional hardware clear sequencer that zeroes the array after reset.

## Interface
- Reset is synchronous and active-high; one clock, `CLK`; reset port `RST`.
- Parameters:
- `WSIZE`, 4: bytes per word; word width `DW = 8*WSIZE`.
- `AW`, 8: address width; depth `DEPTH = 2**AW`.
- `CLEAR_ON_RESET`, 1: 1 = zero every word after reset; 0 = no clear, contents undefined after power-up.
- Ports:
- `CLK`  in  1  clock, all state on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `BUSY`  out  1  high while the clear sequence runs; ports ignored.
- `EN0`  in  1  read enable.
- `A0`  in  AW  read address.
- `Do0`  out  DW  registered read data.
- `WE1`  in  WSIZE  per-byte write enable; byte i = bits [8i+7:8i].
- `A1`  in  AW  write address.
- `Di1`  in  DW  write data.

## Operation
- FSM states: `CLEAR`, `READY`.
- Reset:
  - Enters `CLEAR`, or `READY` if `CLEAR_ON_RESET=0`.
  - Clear counter = 0; `Do0` = 0; `BUSY` = 1 (0 if no clear).
- `CLEAR`:
  - Each cycle writes all-zero to word `cnt`, then increments `cnt`.
  - After writing word DEPTH-1, goes to `READY` and `BUSY` falls.
  - `EN0` and `WE1` are ignored; user writes are dropped and `Do0` holds 0.
- `READY`:
  - Write: each byte with `WE1[i]=1` is stored at `A1`; other bytes are unchanged.
  - Read: with `EN0=1`, `Do0` is loaded with word `A0`. With `EN0=0`, `Do0` holds its last value.
  - Bypass when `EN0=1`, `WE1!=0` and `A0==A1` in the same cycle: `Do0` returns `Di1` for the enabled bytes and the old stored bytes for the rest (write-first).
- `RST` asserted mid-clear restarts the clear from word 0. `RST` in `READY` does not alter array contents when `CLEAR_ON_RESET=0`.
- The address is always in range because depth is a power of two; there is no error path.

## Timing
- Read latency 1: `A0`/`EN0` sampled at edge N, `Do0` valid after edge N.
- Write takes effect at edge N. A read of the same address at edge N+1 returns the new data; the same-edge case is covered by the bypass.
- `BUSY` is high for exactly DEPTH cycles after the first edge with `RST=0`. The first accepted request is in the cycle where `BUSY=0`.
- `BUSY` and `Do0` are driven from flops; there is no combinational input-to-output path.

## Structure
- Package `dffram_pkg` holds:
  - The state enum `dffram_state_t {CLEAR, READY}`.
  - Helper function `byte_merge(old, new, we)` used by the bypass.
- Sub-module `dffram_word`: one DW-bit word with per-byte write enables. The top instantiates DEPTH copies.
- The top contains:
  - The write decoder, including the clear-override mux.
  - The read mux.
  - The bypass merge.
  - The FSM and counter.

## Test plan
- Reset, `CLEAR_ON_RESET=1`, AW=8: `BUSY` high for 256 cycles, then 0. Reads of addresses 0, 0x7F and 0xFF return 0.
- Write 0xDEADBEEF to 0x10 with `WE1=4'hF`, then write `WE1=4'b0010`, `Di1=0x0000AA00`. Reading 0x10 one cycle later returns 0xDEADAAEF.
- Same-cycle `A0=A1=0x20` (old value 0x11223344), `WE1=4'b0001`, `Di1=0xFFFFFF99`: `Do0=0x11223399` next cycle.
- `WE1=4'hF` to 0x05 while `BUSY=1`: after the clear, reading 0x05 returns 0. `Do0` stays 0 throughout.
- `RST` pulsed at clear cycle 100: `BUSY` then stays high 256 more cycles. Word 0x30, written before that pulse, reads 0.
- `EN0=0` after reading 0x12345678: `Do0` holds 0x12345678 while `A0` toggles. `WSIZE=2`, `AW=4` instance passes the same checks.

Source files
------------

// File: rtl/dffram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dffram_pkg
// Description : Shared types and helpers for the two-port register-file RAM.
// Revision    : 1.0  initial release
// ============================================================================
package dffram_pkg;

    // Sequencer state: CLEAR zeroes the array, READY serves the ports.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } dffram_state_t;

    // Selects the freshly written byte when its enable is set, else the stored byte.
    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       we
    );
        return we ? new_b : old_b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dffram_word.sv
`default_nettype none
// ============================================================================
// Module      : dffram_word
// Description : One storage word of the register file with per-byte enables.
// Revision    : 1.0  initial release
// ============================================================================
module dffram_word
    import dffram_pkg::*;
#(
    parameter int WSIZE = 4
) (
    input  logic                 clk,
    input  logic [WSIZE-1:0]     i_we,
    input  logic [8*WSIZE-1:0]   i_d,
    output logic [8*WSIZE-1:0]   o_q
);

    logic [8*WSIZE-1:0] r_q;

    // Store each enabled byte; disabled bytes keep their contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WSIZE; i++) begin
            if (i_we[i]) begin
                r_q[8*i +: 8] <= i_d[8*i +: 8];
            end
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/dffram_2p.sv
`default_nettype none
// ============================================================================
// Module      : dffram_2p
// Description : Parametrised two-port register-file RAM. Port 0 is a
//               registered synchronous read, port 1 a byte-masked write.
//               Same-address read/write returns the written bytes
//               (write-first). An optional sequencer zeroes every word after
//               reset while BUSY is high.
// Revision    : 1.0  initial release
// ============================================================================
module dffram_2p
    import dffram_pkg::*;
#(
    parameter int WSIZE          = 4,
    parameter int AW             = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    output logic                 BUSY,
    input  logic                 EN0,
    input  logic [AW-1:0]        A0,
    output logic [8*WSIZE-1:0]   Do0,
    input  logic [WSIZE-1:0]     WE1,
    input  logic [AW-1:0]        A1,
    input  logic [8*WSIZE-1:0]   Di1
);

    localparam int          c_DW    = 8 * WSIZE;
    localparam int          c_DEPTH = 2 ** AW;
    localparam logic [AW-1:0] c_LAST = {AW{1'b1}};

    dffram_state_t   r_state;
    logic [AW-1:0]   r_cnt;
    logic            r_busy;
    logic [c_DW-1:0] r_do0;

    logic [c_DW-1:0] w_q [c_DEPTH];
    logic [c_DW-1:0] w_wdata;
    logic [c_DW-1:0] w_rd;
    logic [c_DW-1:0] w_rd_merged;
    logic            w_clear_wr;
    logic            w_user_wr;
    logic            w_hit;

    // Writes are suppressed while RST is high so a reset never disturbs
    // the array; the clear sequence owns the write port while active.
    assign w_clear_wr = (r_state == CLEAR) && !RST;
    assign w_user_wr  = (r_state == READY) && !RST;
    assign w_wdata    = w_clear_wr ? '0 : Di1;

    generate
        for (genvar k = 0; k < c_DEPTH; k++) begin : g_word
            logic [WSIZE-1:0] w_we;

            // Per-word enable: clear counter match overrides the user decoder.
            assign w_we = (w_clear_wr && (r_cnt == AW'(k))) ? {WSIZE{1'b1}} :
                          (w_user_wr  && (A1    == AW'(k))) ? WE1 : '0;

            dffram_word #(
                .WSIZE (WSIZE)
            ) u_word (
                .clk  (CLK),
                .i_we (w_we),
                .i_d  (w_wdata),
                .o_q  (w_q[k])
            );
        end
    endgenerate

    // Read mux and write-first bypass for a same-address, same-cycle write.
    assign w_rd  = w_q[A0];
    assign w_hit = (A0 == A1) && (WE1 != '0);

    generate
        for (genvar i = 0; i < WSIZE; i++) begin : g_bypass
            assign w_rd_merged[8*i +: 8] =
                byte_merge(w_rd[8*i +: 8], Di1[8*i +: 8], WE1[i] & w_hit);
        end
    endgenerate

    // Sequencer FSM, clear counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
            r_do0 <= '0;
            if (CLEAR_ON_RESET != 0) begin
                r_state <= CLEAR;
                r_busy  <= 1'b1;
            end else begin
                r_state <= READY;
                r_busy  <= 1'b0;
            end
        end else begin
            case (r_state)
                CLEAR: begin
                    r_do0 <= '0;
                    r_cnt <= r_cnt + AW'(1);
                    if (r_cnt == c_LAST) begin
                        r_state <= READY;
                        r_busy  <= 1'b0;
                    end
                end
                READY: begin
                    if (EN0) begin
                        r_do0 <= w_rd_merged;
                    end
                end
                default: begin
                    r_state <= READY;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY = r_busy;
    assign Do0  = r_do0;

endmodule
`default_nettype wire

// File: tb/tb_dffram_2p.sv
`default_nettype none
// ============================================================================
// Module      : tb_dffram_2p
// Description : Directed self-checking bench for dffram_2p, covering a
//               32-bit x 256 instance and a 16-bit x 16 instance.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dffram_2p;

    logic clk;

    // Instance A: WSIZE=4, AW=8
    logic        rst_a, en0_a, busy_a;
    logic [7:0]  a0_a, a1_a;
    logic [3:0]  we1_a;
    logic [31:0] di1_a, do0_a;

    // Instance B: WSIZE=2, AW=4
    logic        rst_b, en0_b, busy_b;
    logic [3:0]  a0_b, a1_b;
    logic [1:0]  we1_b;
    logic [15:0] di1_b, do0_b;

    int n_tests;
    int n_fail;
    int cnt;
    logic [31:0] exp_q[$];

    dffram_2p #(.WSIZE(4), .AW(8), .CLEAR_ON_RESET(1)) dut_a (
        .CLK(clk), .RST(rst_a), .BUSY(busy_a), .EN0(en0_a), .A0(a0_a),
        .Do0(do0_a), .WE1(we1_a), .A1(a1_a), .Di1(di1_a)
    );

    dffram_2p #(.WSIZE(2), .AW(4), .CLEAR_ON_RESET(1)) dut_b (
        .CLK(clk), .RST(rst_b), .BUSY(busy_b), .EN0(en0_b), .A0(a0_b),
        .Do0(do0_b), .WE1(we1_b), .A1(a1_b), .Di1(di1_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled and inputs driven 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input logic [7:0] a, input logic [3:0] we, input logic [31:0] d);
        we1_a = we; a1_a = a; di1_a = d;
        cyc();
        we1_a = '0;
    endtask

    task automatic rd_a(input string tag, input logic [7:0] a, input logic [31:0] exp);
        en0_a = 1'b1; a0_a = a;
        exp_q.push_back(exp);
        cyc();
        en0_a = 1'b0;
        check(tag, do0_a, exp_q.pop_front());
    endtask

    task automatic wr_b(input logic [3:0] a, input logic [1:0] we, input logic [15:0] d);
        we1_b = we; a1_b = a; di1_b = d;
        cyc();
        we1_b = '0;
    endtask

    task automatic rd_b(input string tag, input logic [3:0] a, input logic [15:0] exp);
        en0_b = 1'b1; a0_b = a;
        exp_q.push_back({16'h0, exp});
        cyc();
        en0_b = 1'b0;
        check(tag, {16'h0, do0_b}, exp_q.pop_front());
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst_a = 1'b1; en0_a = 1'b0; a0_a = '0; a1_a = '0; we1_a = '0; di1_a = '0;
        rst_b = 1'b1; en0_b = 1'b0; a0_b = '0; a1_b = '0; we1_b = '0; di1_b = '0;

        // ---------------- Instance A ----------------
        cyc(); cyc();
        check("a_rst_busy", {31'h0, busy_a}, 32'h1);
        check("a_rst_do0", do0_a, 32'h0);
        rst_a = 1'b0;

        // Clear runs with user traffic that must be ignored.
        we1_a = 4'hF; a1_a = 8'h05; di1_a = 32'hFFFF_FFFF;
        en0_a = 1'b1; a0_a = 8'h05;
        cnt = 0;
        while (busy_a && cnt < 1000) begin
            check("a_clr_do0", do0_a, 32'h0);
            cnt++;
            cyc();
        end
        we1_a = '0; en0_a = 1'b0;
        check("a_busy_len", cnt, 32'd256);
        check("a_busy_low", {31'h0, busy_a}, 32'h0);
        check("a_do0_after_clr", do0_a, 32'h0);

        rd_a("a_rd_00", 8'h00, 32'h0);
        rd_a("a_rd_7f", 8'h7F, 32'h0);
        rd_a("a_rd_ff", 8'hFF, 32'h0);
        rd_a("a_rd_05_dropped", 8'h05, 32'h0);

        // Byte-masked write
        wr_a(8'h10, 4'hF, 32'hDEAD_BEEF);
        wr_a(8'h10, 4'b0010, 32'h0000_AA00);
        rd_a("a_mask", 8'h10, 32'hDEAD_AAEF);

        // Different-address write does not bypass
        we1_a = 4'hF; a1_a = 8'h11; di1_a = 32'h5555_5555;
        rd_a("a_nobypass", 8'h10, 32'hDEAD_AAEF);
        rd_a("a_rd_11", 8'h11, 32'h5555_5555);

        // Same-cycle bypass, write-first
        wr_a(8'h20, 4'hF, 32'h1122_3344);
        we1_a = 4'b0001; a1_a = 8'h20; di1_a = 32'hFFFF_FF99;
        rd_a("a_bypass", 8'h20, 32'h1122_3399);
        rd_a("a_bypass_stored", 8'h20, 32'h1122_3399);

        // Hold with EN0 low
        wr_a(8'h40, 4'hF, 32'h1234_5678);
        rd_a("a_rd_40", 8'h40, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            a0_a = (i[0]) ? 8'h10 : 8'h20;
            cyc();
            check("a_hold", do0_a, 32'h1234_5678);
        end

        // Reset pulse mid-clear restarts from word 0
        wr_a(8'h30, 4'hF, 32'hCAFE_F00D);
        rd_a("a_rd_30", 8'h30, 32'hCAFE_F00D);
        rst_a = 1'b1; cyc(); rst_a = 1'b0;
        for (int i = 0; i < 100; i++) cyc();
        check("a_busy_mid", {31'h0, busy_a}, 32'h1);
        rst_a = 1'b1; cyc(); rst_a = 1'b0;
        cnt = 0;
        while (busy_a && cnt < 1000) begin
            cnt++;
            cyc();
        end
        check("a_busy_restart", cnt, 32'd256);
        rd_a("a_rd_30_cleared", 8'h30, 32'h0);
        rd_a("a_rd_40_cleared", 8'h40, 32'h0);

        // ---------------- Instance B ----------------
        cyc();
        check("b_rst_busy", {31'h0, busy_b}, 32'h1);
        check("b_rst_do0", {16'h0, do0_b}, 32'h0);
        rst_b = 1'b0;
        we1_b = 2'b11; a1_b = 4'h5; di1_b = 16'hFFFF;
        cnt = 0;
        while (busy_b && cnt < 100) begin
            cnt++;
            cyc();
        end
        we1_b = '0;
        check("b_busy_len", cnt, 32'd16);
        rd_b("b_rd_0", 4'h0, 16'h0);
        rd_b("b_rd_f", 4'hF, 16'h0);
        rd_b("b_rd_5_dropped", 4'h5, 16'h0);

        wr_b(4'h3, 2'b11, 16'hBEEF);
        wr_b(4'h3, 2'b10, 16'hAA00);
        rd_b("b_mask", 4'h3, 16'hAAEF);

        wr_b(4'h6, 2'b11, 16'h3344);
        we1_b = 2'b01; a1_b = 4'h6; di1_b = 16'hFF99;
        rd_b("b_bypass", 4'h6, 16'h3399);

        wr_b(4'h9, 2'b11, 16'h5678);
        rd_b("b_rd_9", 4'h9, 16'h5678);
        for (int i = 0; i < 3; i++) begin
            a0_b = 4'(i + 1);
            cyc();
            check("b_hold", {16'h0, do0_b}, 32'h0000_5678);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
